proto245_async: RTL and testbench
=================================

Name:
proto245_async

Overview:
- Bridge between an FTDI FT245-style asynchronous parallel FIFO chip and user logic.
- Moves bytes from the chip into an RX FIFO that user logic reads.
- Moves bytes that user logic writes into a TX FIFO out to the chip.
- Single clock domain: both FIFOs and the FT245 strobe state machine run on ft_clk.

Parameters:
- DATA_W, 8, data bus width.
- TX_FIFO_SIZE, 32, TX FIFO depth in words (power of two, >=2).
- RX_FIFO_SIZE, 32, RX FIFO depth in words (power of two, >=2).
- READ_TICKS, 4, ft_clk cycles ft_rdn is held low per read (>=2).
- WRITE_TICKS, 4, ft_clk cycles ft_wrn is held low per write (>=2).

Ports:
- ft_clk  in  1  single clock for the whole block.
- ft_rst  in  1  synchronous reset, active-low.
- ft_rxfn  in  1  chip has RX data when low; asynchronous.
- ft_txen  in  1  chip can accept TX data when low; asynchronous.
- ft_din  in  DATA_W  data from chip.
- ft_dout  out  DATA_W  data to chip.
- ft_rdn  out  1  read strobe, active-low.
- ft_wrn  out  1  write strobe, active-low.
- ft_siwu  out  1  send-immediate; tied high.
- rxfifo_rd  in  1  pop request.
- rxfifo_data  out  DATA_W  popped word.
- rxfifo_valid  out  1  rxfifo_data valid pulse.
- rxfifo_load  out  clog2(RX_FIFO_SIZE)+1  RX occupancy.
- rxfifo_empty  out  1  RX FIFO empty.
- txfifo_data  in  DATA_W  word to push.
- txfifo_wr  in  1  push request.
- txfifo_load  out  clog2(TX_FIFO_SIZE)+1  TX occupancy.
- txfifo_full  out  1  TX FIFO full.

Behaviour:
Reset:
- ft_rst low at a clock edge gives: ft_rdn=1, ft_wrn=1, ft_dout=0, ft_siwu=1, rxfifo_valid=0, rxfifo_data=0, rxfifo_empty=1, rxfifo_load=0, txfifo_load=0, txfifo_full=0.
- Both FIFOs are cleared and the FSM goes to IDLE.
- Reset asserted mid-transaction deasserts the strobe at that edge; the partial byte is discarded.

Input synchronisation:
- ft_rxfn and ft_txen each pass through a 2-flop synchronizer before use.

FSM states: IDLE, RD, WR, GAP.
- IDLE -> RD when synced rxfn=0 and RX FIFO has at least one free slot.
- IDLE -> WR when synced txen=0 and TX FIFO is not empty.
- Both eligible: round-robin; the direction not served last wins. After reset, read has priority.
- RD: ft_rdn=0 for exactly READ_TICKS cycles. ft_din is sampled on the edge ending the last low cycle and pushed into the RX FIFO on that edge. ft_rdn then returns to 1 and the FSM enters GAP.
- WR: ft_dout is loaded with the TX FIFO head one cycle before ft_wrn falls. ft_wrn=0 for exactly WRITE_TICKS cycles, then returns to 1. The TX word is popped as ft_wrn rises. ft_dout holds its value until the next write loads a new word. Then GAP.
- GAP: both strobes high for 3 cycles so synchronized flags reflect the chip's post-strobe state, then IDLE.
- Strobes are never low simultaneously.

RX FIFO (user side):
- rxfifo_rd=1 while not empty pops one word.
- rxfifo_data updates and rxfifo_valid=1 one cycle after the rd edge, for one cycle.
- rxfifo_rd while empty is ignored; valid stays 0.

TX FIFO (user side):
- txfifo_wr=1 while not full pushes txfifo_data.
- txfifo_wr while full is dropped; contents are unchanged.

Occupancy flags:
- load, empty and full are registered and reflect the count after the current edge.
- A simultaneous push and pop leaves load unchanged.
- Pointers wrap modulo size. load ranges 0..SIZE; full when load==SIZE, empty when load==0.

Ordering:
- Strict FIFO order in both directions; no duplication or loss except dropped overflow writes.

Test Plan:
- RX stream: model supplies 0x00..0x1F with rxfn low; user reads all 32 -> rxfifo_data sequence 0x00..0x1F with valid pulses; every ft_rdn low pulse is exactly 4 cycles.
- TX stream: user writes 0xA0..0xBF with txen low -> ft_dout at each ft_wrn rise equals 0xA0..0xBF in order; every ft_wrn low pulse is exactly 4 cycles; txfifo_load returns to 0.
- RX backpressure: model offers 40 bytes, user does not read -> rxfifo_load stops at 32 and ft_rdn stays high. Draining then yields all 40 bytes in order.
- TX overflow/stall: txen held high, user writes 34 words -> txfifo_full=1 at load 32 and the last 2 words are dropped. Releasing txen sends exactly the first 32.
- Bidirectional: rxfn and txen both low with data pending -> reads and writes alternate; strobes never overlap; both streams are intact.
- Reset mid-read: assert ft_rst during an ft_rdn low pulse -> ft_rdn=1 and rxfifo_empty=1 after the edge. After release the next byte is received normally.

Source files
------------

// File: rtl/proto245_async.sv
// FT245-style asynchronous FIFO bridge: chip bytes go into an RX FIFO for user
// logic, and user bytes go from a TX FIFO out to the chip, all on ft_clk.
// Ports:
//   ft_*      : chip side. rxfn/txen are async inputs; rdn/wrn are active-low strobes.
//   rxfifo_*  : user pop side (rd -> data/valid one cycle later, load, empty).
//   txfifo_*  : user push side (data/wr, load, full).
module proto245_async #(
    parameter int DATA_W       = 8,
    parameter int TX_FIFO_SIZE = 32,
    parameter int RX_FIFO_SIZE = 32,
    parameter int READ_TICKS   = 4,
    parameter int WRITE_TICKS  = 4
) (
    input  logic                            ft_clk,
    input  logic                            ft_rst,
    input  logic                            ft_rxfn,
    input  logic                            ft_txen,
    input  logic [DATA_W-1:0]               ft_din,
    output logic [DATA_W-1:0]               ft_dout,
    output logic                            ft_rdn,
    output logic                            ft_wrn,
    output logic                            ft_siwu,
    input  logic                            rxfifo_rd,
    output logic [DATA_W-1:0]               rxfifo_data,
    output logic                            rxfifo_valid,
    output logic [$clog2(RX_FIFO_SIZE):0]   rxfifo_load,
    output logic                            rxfifo_empty,
    input  logic [DATA_W-1:0]               txfifo_data,
    input  logic                            txfifo_wr,
    output logic [$clog2(TX_FIFO_SIZE):0]   txfifo_load,
    output logic                            txfifo_full
);

    localparam int RX_AW = $clog2(RX_FIFO_SIZE);
    localparam int TX_AW = $clog2(TX_FIFO_SIZE);
    localparam int MAX_T = (READ_TICKS > WRITE_TICKS) ? READ_TICKS : WRITE_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1) + 1;
    localparam logic [RX_AW:0] RX_N = (RX_AW + 1)'(RX_FIFO_SIZE);
    localparam logic [TX_AW:0] TX_N = (TX_AW + 1)'(TX_FIFO_SIZE);

    typedef enum logic [1:0] {IDLE, RD, WR, GAP} state_t;

    logic [DATA_W-1:0] rx_mem [RX_FIFO_SIZE];
    logic [DATA_W-1:0] tx_mem [TX_FIFO_SIZE];

    logic rxfn_s1_q, rxfn_s2_q, txen_s1_q, txen_s2_q;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic last_rd_q, last_rd_d;
    logic rdn_q, rdn_d, wrn_q, wrn_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RX_AW:0] rx_cnt_q, rx_cnt_d;
    logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TX_AW:0] tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic rx_valid_q, rx_valid_d;

    logic rx_push, rx_pop, tx_push, tx_pop;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rd_ok, wr_ok;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_N);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TX_N);
    assign rx_pop   = rxfifo_rd && !rx_empty;
    assign tx_push  = txfifo_wr && !tx_full;
    assign rd_ok    = !rxfn_s2_q && !rx_full;
    assign wr_ok    = !txen_s2_q && !tx_empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        rdn_d     = rdn_q;
        wrn_d     = wrn_q;
        dout_d    = dout_q;
        rx_push   = 1'b0;
        tx_pop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Round-robin: read wins unless the last transfer was a read.
                if (rd_ok && (!wr_ok || !last_rd_q)) begin
                    state_d   = RD;
                    rdn_d     = 1'b0;
                    last_rd_d = 1'b1;
                end else if (wr_ok) begin
                    // Data is set up one cycle ahead of the wrn falling edge.
                    state_d   = WR;
                    dout_d    = tx_mem[tx_rp_q];
                    last_rd_d = 1'b0;
                end
            end
            RD: begin
                if (cnt_q == CNT_W'(READ_TICKS - 1)) begin
                    rx_push = 1'b1;
                    rdn_d   = 1'b1;
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                if (cnt_q == '0) begin
                    wrn_d = 1'b0;
                end
                if (cnt_q == CNT_W'(WRITE_TICKS)) begin
                    tx_pop  = 1'b1;
                    wrn_d   = 1'b1;
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                // Lets the 2-flop synced flags catch up with the chip.
                if (cnt_q == CNT_W'(2)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_wp_d    = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
        rx_rp_d    = rx_pop ? rx_rp_q + 1'b1 : rx_rp_q;
        tx_wp_d    = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
        tx_rp_d    = tx_pop ? tx_rp_q + 1'b1 : tx_rp_q;
        rx_cnt_d   = rx_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
        rx_data_d  = rx_pop ? rx_mem[rx_rp_q] : rx_data_q;
        rx_valid_d = rx_pop;
    end

    always_ff @(posedge ft_clk) begin
        if (ft_rst && rx_push) rx_mem[rx_wp_q] <= ft_din;
        if (ft_rst && tx_push) tx_mem[tx_wp_q] <= txfifo_data;
    end

    always_ff @(posedge ft_clk) begin
        if (!ft_rst) begin
            rxfn_s1_q  <= 1'b1;
            rxfn_s2_q  <= 1'b1;
            txen_s1_q  <= 1'b1;
            txen_s2_q  <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_rd_q  <= 1'b0;
            rdn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            dout_q     <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rxfn_s1_q  <= ft_rxfn;
            rxfn_s2_q  <= rxfn_s1_q;
            txen_s1_q  <= ft_txen;
            txen_s2_q  <= txen_s1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_rd_q  <= last_rd_d;
            rdn_q      <= rdn_d;
            wrn_q      <= wrn_d;
            dout_q     <= dout_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign ft_rdn       = rdn_q;
    assign ft_wrn       = wrn_q;
    assign ft_dout      = dout_q;
    assign ft_siwu      = 1'b1;
    assign rxfifo_data  = rx_data_q;
    assign rxfifo_valid = rx_valid_q;
    assign rxfifo_load  = rx_cnt_q;
    assign rxfifo_empty = rx_empty;
    assign txfifo_load  = tx_cnt_q;
    assign txfifo_full  = tx_full;

endmodule

// File: tb/tb_proto245_async.sv
// Bench for proto245_async: chip model plus queue-based reference of both FIFOs.
module tb_proto245_async;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxfn = 1'b1;
    logic txen;
    logic [7:0] din = 8'h00;
    logic [7:0] dout, rdata;
    logic rdn, wrn, siwu, rvalid, rempty, tfull;
    logic rd = 1'b0;
    logic twr = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic [5:0] rload, tload;

    always #5 clk = ~clk;

    proto245_async dut (
        .ft_clk(clk), .ft_rst(rst_n), .ft_rxfn(rxfn), .ft_txen(txen),
        .ft_din(din), .ft_dout(dout), .ft_rdn(rdn), .ft_wrn(wrn),
        .ft_siwu(siwu), .rxfifo_rd(rd), .rxfifo_data(rdata),
        .rxfifo_valid(rvalid), .rxfifo_load(rload), .rxfifo_empty(rempty),
        .txfifo_data(tdata), .txfifo_wr(twr), .txfifo_load(tload),
        .txfifo_full(tfull)
    );

    bit rx_en = 0;
    bit tx_en = 0;
    assign txen = ~tx_en;

    logic [7:0] chip_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_got[$];
    logic [7:0] tx_got[$];
    bit dir_log[$];

    int tests = 0;
    int errors = 0;
    int m_rx = 0;
    int m_tx = 0;
    int rd_low = 0;
    int wr_low = 0;
    logic prev_rdn = 1'b1;
    logic prev_wrn = 1'b1;
    logic rst_e = 1'b0;
    logic rd_e = 1'b0;
    logic wr_e = 1'b0;
    logic [7:0] td_e = 8'h00;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        rst_e = rst_n;
        rd_e  = rd;
        wr_e  = twr;
        td_e  = tdata;
    end

    // Reference: counts and data queues derived from observed strobe edges
    // and user requests, compared on every falling edge.
    always @(negedge clk) begin
        logic rr, wrs, pe, pu;
        logic [7:0] b;
        rr  = !prev_rdn && rdn;
        wrs = !prev_wrn && wrn;
        if (!rst_e) begin
            m_rx = 0;
            m_tx = 0;
            exp_rx.delete();
            exp_tx.delete();
            if (rr && chip_q.size() > 0) void'(chip_q.pop_front());
            chk("reset_out",
                {rdn, wrn, siwu, rvalid, rempty, tfull, dout, rdata, rload, tload},
                {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 6'd0, 6'd0});
            rd_low = 0;
            wr_low = 0;
        end else begin
            pe = rd_e && (m_rx > 0);
            pu = wr_e && (m_tx < N);
            if (rr) begin
                chk("rdn_pulse_len", rd_low, 4);
                chk("chip_has_byte", chip_q.size() > 0, 1);
                if (chip_q.size() > 0) begin
                    b = chip_q.pop_front();
                    exp_rx.push_back(b);
                    m_rx++;
                end
                dir_log.push_back(1'b1);
            end
            if (pe) m_rx--;
            chk("rx_valid", rvalid, pe);
            if (pe) begin
                b = exp_rx.size() > 0 ? exp_rx.pop_front() : 8'hxx;
                chk("rx_data", rdata, b);
                rx_got.push_back(rdata);
            end
            if (wrs) begin
                chk("wrn_pulse_len", wr_low, 4);
                b = exp_tx.size() > 0 ? exp_tx.pop_front() : 8'hxx;
                chk("tx_dout", dout, b);
                tx_got.push_back(dout);
                m_tx--;
                dir_log.push_back(1'b0);
            end
            if (pu) begin
                exp_tx.push_back(td_e);
                m_tx++;
            end
            chk("rx_load", rload, m_rx);
            chk("rx_empty", rempty, m_rx == 0);
            chk("tx_load", tload, m_tx);
            chk("tx_full", tfull, m_tx == N);
            chk("no_overlap", !rdn && !wrn, 0);
            rd_low = rdn ? 0 : rd_low + 1;
            wr_low = wrn ? 0 : wr_low + 1;
        end
        prev_rdn = rdn;
        prev_wrn = wrn;
        rxfn = !(rx_en && chip_q.size() > 0);
        din  = chip_q.size() > 0 ? chip_q[0] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] v);
        twr = 1'b1;
        tdata = v;
        tick();
        twr = 1'b0;
    endtask

    initial begin
        int hi;
        logic [7:0] v;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_empty", rempty, 1);
        chk("post_reset_tload", tload, 0);

        // RX stream 0x00..0x1F with random user reads
        for (int i = 0; i < 32; i++) chip_q.push_back(8'(i));
        rx_en = 1;
        for (int g = 0; g < 4000 && rx_got.size() < 32; g++) begin
            rd = 1'($urandom_range(0, 1));
            tick();
        end
        rd = 1'b0;
        chk("rx_stream_count", rx_got.size(), 32);
        for (int i = 0; i < 32 && i < rx_got.size(); i++)
            chk("rx_stream_val", rx_got[i], 8'(i));

        // TX stream 0xA0..0xBF with random gaps
        tx_en = 1;
        for (int i = 0; i < 32; i++) begin
            push_tx(8'hA0 + 8'(i));
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int g = 0; g < 2000 && tx_got.size() < 32; g++) tick();
        repeat (4) tick();
        chk("tx_stream_count", tx_got.size(), 32);
        for (int i = 0; i < 32 && i < tx_got.size(); i++)
            chk("tx_stream_val", tx_got[i], 8'hA0 + 8'(i));
        chk("tx_stream_load0", tload, 0);

        // RX backpressure: 40 offered, nothing read
        rx_got.delete();
        for (int i = 0; i < 40; i++) chip_q.push_back(8'h40 + 8'(i));
        repeat (600) tick();
        chk("bp_load_32", rload, 32);
        chk("bp_chip_left", chip_q.size(), 8);
        hi = 1;
        repeat (30) begin
            tick();
            if (rdn !== 1'b1) hi = 0;
        end
        chk("bp_rdn_high", hi, 1);
        for (int g = 0; g < 6000 && rx_got.size() < 40; g++) begin
            rd = 1'($urandom_range(0, 1));
            tick();
        end
        rd = 1'b0;
        chk("bp_count", rx_got.size(), 40);
        for (int i = 0; i < 40 && i < rx_got.size(); i++)
            chk("bp_val", rx_got[i], 8'h40 + 8'(i));

        // TX overflow with txen high
        tx_en = 0;
        tx_got.delete();
        repeat (5) tick();
        for (int i = 0; i < 34; i++) push_tx(8'hC0 + 8'(i));
        tick();
        chk("ovf_full", tfull, 1);
        chk("ovf_load", tload, 32);
        chk("ovf_no_send", tx_got.size(), 0);
        tx_en = 1;
        for (int g = 0; g < 3000 && tx_got.size() < 32; g++) tick();
        repeat (50) tick();
        chk("ovf_sent", tx_got.size(), 32);
        for (int i = 0; i < 32 && i < tx_got.size(); i++)
            chk("ovf_val", tx_got[i], 8'hC0 + 8'(i));

        // Bidirectional alternation with random data
        rx_en = 0;
        tx_en = 0;
        repeat (5) tick();
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom);
            chip_q.push_back(v);
            push_tx(8'($urandom));
        end
        repeat (3) tick();
        dir_log.delete();
        rx_en = 1;
        tx_en = 1;
        for (int g = 0; g < 1000 && dir_log.size() < 20; g++) tick();
        chk("bidir_count", dir_log.size(), 20);
        for (int i = 1; i < 20 && i < dir_log.size(); i++)
            chk("bidir_alt", dir_log[i] != dir_log[i-1], 1);
        chk("bidir_rx_load", rload, 10);

        // Reset in the middle of a read pulse
        rx_en = 0;
        repeat (5) tick();
        chip_q.push_back(8'h55);
        chip_q.push_back(8'h66);
        chip_q.push_back(8'h77);
        rx_en = 1;
        for (int g = 0; g < 200 && rdn !== 1'b0; g++) tick();
        chk("mid_rd_seen", rdn, 0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_rdn", rdn, 1);
        chk("mid_rst_empty", rempty, 1);
        rst_n = 1'b1;
        rx_got.delete();
        for (int g = 0; g < 1000 && rx_got.size() < 2; g++) begin
            rd = 1'($urandom_range(0, 1));
            tick();
        end
        rd = 1'b0;
        repeat (20) tick();
        chk("mid_rst_count", rx_got.size(), 2);
        if (rx_got.size() >= 2) begin
            chk("mid_rst_b0", rx_got[0], 8'h66);
            chk("mid_rst_b1", rx_got[1], 8'h77);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
